// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and constants for the banked-memory controllers:
//            load FSM state encoding and bank geometry.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  // Four banks selected by the two top bits of a 16-bit byte address
  localparam int c_num_banks  = 4;
  localparam int c_bank_idx_w = 2;
  localparam int c_bank_hi    = 15;
  localparam int c_bank_lo    = 14;

  // Load controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } load_state_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/bank_decode.sv
`default_nettype none
// ============================================================================
// Module   : bank_decode
// Purpose  : One-hot bank select decoded from a byte address. Shared by the
//            load and read-side controllers.
// Revision : 1.0 - initial release
// ============================================================================
module bank_decode
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [c_num_banks-1:0] o_bank_sel
);

  // Only the bank index bits take part in the decode
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr[c_bank_lo-1:0];

  // Set the single bit addressed by the bank index field
  always_comb begin
    o_bank_sel = '0;
    o_bank_sel[i_addr[c_bank_hi:c_bank_lo]] = 1'b1;
  end

endmodule : bank_decode
`default_nettype wire

// File: rtl/mem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_ctrl
// Purpose  : Streams a counted run of bytes into banked memory starting at a
//            base address. A run ending on an even address is completed to a
//            full 16-bit word with one pad byte. Supports abort and reports
//            errors through a sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] PAD_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      byte_count,
  input  logic                   abort,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_data,
  output logic                   mem_we,
  output logic [c_num_banks-1:0] bank_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_W-1:0]      bytes_written
);

  localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

  load_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_bw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_we;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_bw_next;
  logic              w_last;

  // Abort drops any byte offered in the same cycle, so ready falls with it
  assign w_ready   = (r_state == ST_LOAD) && !abort;
  assign w_accept  = w_ready && s_valid;
  assign w_bw_next = r_bw + c_one;
  assign w_last    = (w_bw_next == r_count);

  // Load FSM with registered memory-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_bw       <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr  <= base_addr;
            r_count <= byte_count;
            r_bw    <= '0;
            if (byte_count == '0) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_accept) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_addr;
            r_mem_data <= s_data;
            r_addr     <= r_addr + c_one;
            r_bw       <= w_bw_next;
            if (w_last) begin
              // Odd last address closes the 16-bit word; even needs a pad
              if (r_addr[0]) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          if (abort) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            // r_addr already points one past the last data byte
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_addr;
            r_mem_data <= PAD_BYTE;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  bank_decode #(
    .ADDR_W (ADDR_W)
  ) u_bank_decode (
    .i_addr     (r_mem_addr),
    .o_bank_sel (bank_sel)
  );

  assign s_ready       = w_ready;
  assign mem_addr      = r_mem_addr;
  assign mem_data      = r_mem_data;
  assign mem_we        = r_mem_we;
  assign busy          = (r_state == ST_LOAD) || (r_state == ST_PAD);
  assign done          = r_done;
  assign err           = r_err;
  assign bytes_written = r_bw;

endmodule : mem_load_ctrl
`default_nettype wire

// File: tb/tb_mem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_load_ctrl
// Purpose  : Directed self-checking bench for mem_load_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] byte_count = '0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic [3:0]  bank_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] bytes_written;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [3:0]  wr_b[$];

  mem_load_ctrl #(
    .ADDR_W   (16),
    .DATA_W   (8),
    .PAD_BYTE (8'h00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .byte_count    (byte_count),
    .abort         (abort),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_we        (mem_we),
    .bank_sel      (bank_sel),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .bytes_written (bytes_written)
  );

  always #5 clk = ~clk;

  // Log every write and every done cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_data);
      wr_b.push_back(bank_sel);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [15:0] a,
                        input logic [7:0] d, input logic [3:0] b);
    if (idx < wr_a.size()) begin
      chk({tag, "_addr"}, 32'(wr_a[idx]), 32'(a));
      chk({tag, "_data"}, 32'(wr_d[idx]), 32'(d));
      chk({tag, "_bank"}, 32'(wr_b[idx]), 32'(b));
    end else begin
      chk({tag, "_missing"}, 32'(wr_a.size()), 32'(idx + 1));
    end
  endtask

  task automatic start_load(input logic [15:0] b, input logic [15:0] c);
    start = 1'b1; base_addr = b; byte_count = c;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    s_valid = 1'b1; s_data = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_mem_we"},  32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    chk({tag, "_bank_sel"}, 32'(bank_sel), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_bw"}, 32'(bytes_written), 32'd0);
  endtask

  initial begin
    int n0;
    int d0;

    // Reset state
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // Aligned run of four back-to-back bytes, no pad
    n0 = wr_a.size(); d0 = done_cnt;
    start_load(16'h0000, 16'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(s_ready), 32'd1);
    send(8'h11); s_valid = 1'b1; s_data = 8'h22; step();
    s_data = 8'h33; step(); s_data = 8'h44; step(); s_valid = 1'b0;
    repeat (5) step();
    chk("t1_nwr", 32'(wr_a.size() - n0), 32'd4);
    chk_wr("t1_w0", n0 + 0, 16'h0000, 8'h11, 4'b0001);
    chk_wr("t1_w1", n0 + 1, 16'h0001, 8'h22, 4'b0001);
    chk_wr("t1_w2", n0 + 2, 16'h0002, 8'h33, 4'b0001);
    chk_wr("t1_w3", n0 + 3, 16'h0003, 8'h44, 4'b0001);
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_bw", 32'(bytes_written), 32'd4);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Bank crossing with stalls, pad at 0x4001
    n0 = wr_a.size(); d0 = done_cnt;
    start_load(16'h3FFE, 16'd3);
    send(8'hA1); step();
    chk("t2_bw_stall", 32'(bytes_written), 32'd1);
    send(8'hA2); step(); step();
    send(8'hA3);
    repeat (5) step();
    chk("t2_nwr", 32'(wr_a.size() - n0), 32'd4);
    chk_wr("t2_w0", n0 + 0, 16'h3FFE, 8'hA1, 4'b0001);
    chk_wr("t2_w1", n0 + 1, 16'h3FFF, 8'hA2, 4'b0001);
    chk_wr("t2_w2", n0 + 2, 16'h4000, 8'hA3, 4'b0010);
    chk_wr("t2_pad", n0 + 3, 16'h4001, 8'h00, 4'b0010);
    chk("t2_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_bw", 32'(bytes_written), 32'd3);
    chk("t2_err", 32'(err), 32'd0);

    // Address wrap from 0xFFFF
    n0 = wr_a.size(); d0 = done_cnt;
    start_load(16'hFFFF, 16'd2);
    send(8'h5A); send(8'hA5);
    repeat (5) step();
    chk("t3_nwr", 32'(wr_a.size() - n0), 32'd3);
    chk_wr("t3_w0", n0 + 0, 16'hFFFF, 8'h5A, 4'b1000);
    chk_wr("t3_w1", n0 + 1, 16'h0000, 8'hA5, 4'b0001);
    chk_wr("t3_pad", n0 + 2, 16'h0001, 8'h00, 4'b0001);
    chk("t3_done", 32'(done_cnt - d0), 32'd1);
    chk("t3_bw", 32'(bytes_written), 32'd2);

    // Zero count: immediate done with error
    n0 = wr_a.size(); d0 = done_cnt;
    start_load(16'h1234, 16'd0);
    chk("t4_done_now", 32'(done), 32'd1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    step();
    chk("t4_done_off", 32'(done), 32'd0);
    repeat (3) step();
    chk("t4_nwr", 32'(wr_a.size() - n0), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t4_err_sticky", 32'(err), 32'd1);

    // Abort after two of five bytes; start while busy ignored
    n0 = wr_a.size(); d0 = done_cnt;
    start_load(16'h1000, 16'd5);
    chk("t5_err_cleared", 32'(err), 32'd0);
    send(8'hB1);
    start = 1'b1; base_addr = 16'h2000; byte_count = 16'd9;
    send(8'hB2);
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'hEE; abort = 1'b1;
    #1;
    chk("t5_ready_abort", 32'(s_ready), 32'd0);
    step();
    abort = 1'b0; s_valid = 1'b0;
    repeat (5) step();
    chk("t5_nwr", 32'(wr_a.size() - n0), 32'd2);
    chk_wr("t5_w0", n0 + 0, 16'h1000, 8'hB1, 4'b0001);
    chk_wr("t5_w1", n0 + 1, 16'h1001, 8'hB2, 4'b0001);
    chk("t5_done", 32'(done_cnt - d0), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_bw", 32'(bytes_written), 32'd2);

    // Reset mid-load, then a clean run
    n0 = wr_a.size(); d0 = done_cnt;
    start_load(16'h8000, 16'd4);
    send(8'hC1); send(8'hC2);
    rst = 1'b1;
    step();
    chk_reset_vals("t6_rst");
    rst = 1'b0;
    repeat (4) step();
    chk("t6_nwr", 32'(wr_a.size() - n0), 32'd2);
    chk_wr("t6_w1", n0 + 1, 16'h8001, 8'hC2, 4'b0100);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    n0 = wr_a.size(); d0 = done_cnt;
    start_load(16'h0010, 16'd1);
    send(8'h77);
    repeat (5) step();
    chk("t6b_nwr", 32'(wr_a.size() - n0), 32'd2);
    chk_wr("t6b_w0", n0 + 0, 16'h0010, 8'h77, 4'b0001);
    chk_wr("t6b_pad", n0 + 1, 16'h0011, 8'h00, 4'b0001);
    chk("t6b_done", 32'(done_cnt - d0), 32'd1);
    chk("t6b_bw", 32'(bytes_written), 32'd1);
    chk("t6b_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_load_ctrl
`default_nettype wire
